a8_bus_capture: RTL and testbench

Parametrised capture engine for the Atari 8-bit expansion bus, running in the 200 MHz `clk200` domain beside the passive bus monitor. It recovers each A8 bus cycle from the asynchronous `a8_clk` (phi2) and samples address, data, R/W and /HALT. It filters cycles through `NUM_WIN` programmable address windows with per-window read/write mode. Matching cycles are queued, time-stamped, in a `DEPTH`-entry FIFO with a valid/ready output for downstream logic (trace buffer, register mirror).

---
 rtl/a8_bus_capture.sv | 187 ++++++++++++++++++
 tb/tb_a8_bus_capture.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/a8_bus_capture.sv
// a8_bus_capture: recovers Atari 8-bit bus cycles from phi2 in the clk200
// domain, filters them through programmable address windows and queues
// matching cycles, time-stamped, in a first-word-fall-through FIFO.
module a8_bus_capture #(
  parameter int NUM_WIN    = 4,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_DLY = 48,
  parameter int TS_W       = 16,
  localparam int WIN_W     = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1,
  localparam int E_W       = TS_W + WIN_W + 26,
  localparam int AW        = $clog2(DEPTH),
  localparam int CNT_W     = (SAMPLE_DLY > 1) ? $clog2(SAMPLE_DLY) : 1
) (
  input  logic                   clk200,
  input  logic                   rst_n,
  input  logic                   a8_clk,
  input  logic                   a8_rw_n,
  input  logic                   a8_halt_n,
  input  logic [15:0]            a8_addr,
  input  logic [7:0]             a8_data,
  input  logic                   enable,
  input  logic [NUM_WIN*16-1:0]  cfg_lo,
  input  logic [NUM_WIN*16-1:0]  cfg_hi,
  input  logic [NUM_WIN*2-1:0]   cfg_mode,
  input  logic                   clr_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [E_W-1:0]         out_data,
  output logic [AW:0]            fifo_count,
  output logic                   ovf,
  output logic [15:0]            ovf_count
);

  // Saturating increment for the drop counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Window match: inclusive bounds (lo > hi can never match) and a mode bit
  // selecting reads (bit0) and/or writes (bit1).
  function automatic logic win_hit(input logic [15:0] lo, input logic [15:0] hi,
                                   input logic [1:0] mode, input logic [15:0] addr,
                                   input logic rw_n);
    return (addr >= lo) && (addr <= hi) && (rw_n ? mode[0] : mode[1]);
  endfunction

  // ---- p0: phi2 synchroniser and edge detect ----
  logic sync_p0, sync_p1, sync_p2;
  logic ph_rise;

  assign ph_rise = sync_p1 & ~sync_p2;

  // Two-flop synchroniser plus edge register on phi2.
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= a8_clk;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  logic [TS_W-1:0]  ts;
  logic [CNT_W-1:0] dly_cnt;
  logic             dly_run;
  logic             sample_now;

  // A fresh phi2 edge aborts a still-pending sample rather than taking it.
  assign sample_now = dly_run && (dly_cnt == '0) && !ph_rise;

  // Cycle timestamp and sample delay counter, both restarted by each phi2 edge.
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      ts      <= '0;
      dly_cnt <= '0;
      dly_run <= 1'b0;
    end else begin
      if (ph_rise) begin
        ts      <= ts + 1'b1;
        dly_cnt <= CNT_W'(SAMPLE_DLY - 1);
        dly_run <= 1'b1;
      end else if (dly_run) begin
        if (dly_cnt == '0) dly_run <= 1'b0;
        else               dly_cnt <= dly_cnt - 1'b1;
      end
    end
  end

  // ---- p1: bus sample latched at cycle S ----
  logic              vld_p1;
  logic [15:0]       smp_addr_p1;
  logic [7:0]        smp_data_p1;
  logic              smp_rw_p1;
  logic              smp_halt_p1;
  logic [TS_W-1:0]   smp_ts_p1;

  // Sample-valid strobe for the compare stage.
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) vld_p1 <= 1'b0;
    else        vld_p1 <= sample_now;
  end

  // Bus values are settled by the sample point, so they are taken raw.
  always_ff @(posedge clk200) begin
    if (sample_now) begin
      smp_addr_p1 <= a8_addr;
      smp_data_p1 <= a8_data;
      smp_rw_p1   <= a8_rw_n;
      smp_halt_p1 <= a8_halt_n;
      smp_ts_p1   <= ts;
    end
  end

  logic             hit;
  logic [WIN_W-1:0] hit_win;

  // Priority encode window hits; scanning downward leaves the lowest index.
  always_comb begin
    hit     = 1'b0;
    hit_win = '0;
    for (int i = NUM_WIN - 1; i >= 0; i--) begin
      if (win_hit(cfg_lo[16*i +: 16], cfg_hi[16*i +: 16], cfg_mode[2*i +: 2],
                  smp_addr_p1, smp_rw_p1)) begin
        hit     = 1'b1;
        hit_win = WIN_W'(i);
      end
    end
  end

  logic           push_req, push_ok, pop, full, drop;
  logic [E_W-1:0] entry;

  assign entry    = {smp_ts_p1, hit_win, smp_halt_p1, smp_rw_p1, smp_addr_p1, smp_data_p1};
  assign push_req = vld_p1 & enable & hit;
  assign full     = (fifo_count == (AW+1)'(DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop      = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_ok  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  // ---- p2: FIFO storage and occupancy ----
  logic [E_W-1:0] mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;

  // Entry storage; contents need no reset since occupancy gates the output.
  always_ff @(posedge clk200) begin
    if (push_ok) mem[wr_ptr] <= entry;
  end

  // Read/write pointers and occupancy counter.
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // Sticky overflow flag and drop counter; a drop beats a coincident clear.
  always_ff @(posedge clk200 or negedge rst_n) begin
    if (!rst_n) begin
      ovf       <= 1'b0;
      ovf_count <= '0;
    end else if (drop) begin
      ovf       <= 1'b1;
      ovf_count <= clr_ovf ? 16'd1 : sat_inc16(ovf_count);
    end else if (clr_ovf) begin
      ovf       <= 1'b0;
      ovf_count <= '0;
    end
  end

endmodule

// File: tb/tb_a8_bus_capture.sv
// Directed bench for a8_bus_capture with a scoreboard queue of expected
// FIFO entries, compared as the DUT hands them out.
`timescale 1ns/1ps
module tb_a8_bus_capture;
  localparam int NUM_WIN = 4;
  localparam int DEPTH   = 16;
  localparam int SDLY    = 48;
  localparam int TS_W    = 8;   // narrow timestamp so the wrap fits a short run
  localparam int WIN_W   = 2;
  localparam int E_W     = TS_W + WIN_W + 26;
  localparam int HALF    = 56;  // ~1.79 MHz phi2 at 200 MHz

  logic                  clk200 = 1'b0;
  logic                  rst_n;
  logic                  a8_clk, a8_rw_n, a8_halt_n;
  logic [15:0]           a8_addr;
  logic [7:0]            a8_data;
  logic                  enable;
  logic [NUM_WIN*16-1:0] cfg_lo, cfg_hi;
  logic [NUM_WIN*2-1:0]  cfg_mode;
  logic                  clr_ovf;
  logic                  out_valid, out_ready;
  logic [E_W-1:0]        out_data;
  logic [4:0]            fifo_count;
  logic                  ovf;
  logic [15:0]           ovf_count;

  a8_bus_capture #(.NUM_WIN(NUM_WIN), .DEPTH(DEPTH), .SAMPLE_DLY(SDLY), .TS_W(TS_W)) dut (
    .clk200(clk200), .rst_n(rst_n), .a8_clk(a8_clk), .a8_rw_n(a8_rw_n),
    .a8_halt_n(a8_halt_n), .a8_addr(a8_addr), .a8_data(a8_data), .enable(enable),
    .cfg_lo(cfg_lo), .cfg_hi(cfg_hi), .cfg_mode(cfg_mode), .clr_ovf(clr_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_count(fifo_count), .ovf(ovf), .ovf_count(ovf_count)
  );

  always #2.5 clk200 = ~clk200;

  int checks = 0;
  int errors = 0;
  logic [E_W-1:0] q[$];
  logic [TS_W-1:0] tb_ts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [E_W-1:0] mk(input logic [TS_W-1:0] ts, input logic [1:0] win,
                                        input logic halt, input logic rw,
                                        input logic [15:0] addr, input logic [7:0] data);
    return {ts, win, halt, rw, addr, data};
  endfunction

  // Scoreboard: every pop must match the oldest expected entry.
  always @(negedge clk200) begin
    if (rst_n && out_valid && out_ready) begin
      check("pop_has_expected", 64'(q.size() > 0), 64'd1);
      if (q.size() > 0) check("pop_data", 64'(out_data), 64'(q.pop_front()));
    end
  end

  task automatic set_win(input int i, input logic [15:0] lo, input logic [15:0] hi,
                         input logic [1:0] mode);
    cfg_lo[16*i +: 16] = lo;
    cfg_hi[16*i +: 16] = hi;
    cfg_mode[2*i +: 2] = mode;
  endtask

  task automatic clear_wins();
    cfg_lo = '1; cfg_hi = '0; cfg_mode = '0;
  endtask

  // One full phi2 cycle; starts and ends 1 ns after a clk200 rising edge.
  task automatic bus_cycle(input logic [15:0] addr, input logic [7:0] data, input logic rw,
                           input bit exp_push, input logic [1:0] win, input int half);
    a8_addr = addr; a8_data = data; a8_rw_n = rw;
    tb_ts++;
    if (exp_push) q.push_back(mk(tb_ts, win, a8_halt_n, rw, addr, data));
    a8_clk = 1'b1;
    repeat (half) @(posedge clk200);
    #1 a8_clk = 1'b0;
    repeat (half) @(posedge clk200);
    #1;
  endtask

  task automatic drain(input string tag);
    int n;
    out_ready = 1'b1;
    n = 0;
    while (fifo_count != 0 && n < 100) begin
      @(posedge clk200); #1;
      n++;
    end
    out_ready = 1'b0;
    check({tag, "_drained"}, 64'(fifo_count), 64'd0);
    check({tag, "_q_empty"}, 64'(q.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; a8_clk = 1'b0; a8_rw_n = 1'b1; a8_halt_n = 1'b1;
    a8_addr = '0; a8_data = '0; enable = 1'b0; clr_ovf = 1'b0; out_ready = 1'b0;
    clear_wins();
    tb_ts = '0;
    repeat (5) @(posedge clk200); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_fifo_count", 64'(fifo_count), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_ovf_count", 64'(ovf_count), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk200); #1;

    // Single write into a register window, with output latency probed.
    set_win(0, 16'hD400, 16'hD4FF, 2'b11);
    enable = 1'b1;
    a8_addr = 16'hD40E; a8_data = 8'h22; a8_rw_n = 1'b0;
    tb_ts++;
    q.push_back(mk(tb_ts, 2'd0, 1'b1, 1'b0, 16'hD40E, 8'h22));
    a8_clk = 1'b1;
    repeat (SDLY + 3) @(posedge clk200); #1;
    check("lat_before", 64'(out_valid), 64'd0);
    @(posedge clk200); #1;
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_count", 64'(fifo_count), 64'd1);
    repeat (HALF - SDLY - 4) @(posedge clk200);
    #1 a8_clk = 1'b0;
    repeat (HALF) @(posedge clk200); #1;
    drain("single");

    // Overlapping windows: lowest index wins, mode filters direction.
    enable = 1'b0;
    clear_wins();
    set_win(0, 16'hD000, 16'hDFFF, 2'b01);
    set_win(1, 16'hD200, 16'hD2FF, 2'b11);
    enable = 1'b1;
    bus_cycle(16'hD20A, 8'h5A, 1'b1, 1'b1, 2'd0, HALF);
    bus_cycle(16'hD20A, 8'hA5, 1'b0, 1'b1, 2'd1, HALF);
    bus_cycle(16'hC000, 8'h11, 1'b1, 1'b0, 2'd0, HALF);
    bus_cycle(16'hD000, 8'h01, 1'b1, 1'b1, 2'd0, HALF);
    bus_cycle(16'hDFFF, 8'h02, 1'b1, 1'b1, 2'd0, HALF);
    bus_cycle(16'hDFFF, 8'h03, 1'b0, 1'b0, 2'd0, HALF);
    a8_halt_n = 1'b0;
    bus_cycle(16'hD2FF, 8'h04, 1'b0, 1'b1, 2'd1, HALF);
    a8_halt_n = 1'b1;
    drain("windows");

    // Overflow: 20 matching cycles into a 16-entry FIFO with no reader.
    enable = 1'b0;
    clear_wins();
    set_win(0, 16'h0000, 16'hFFFF, 2'b11);
    enable = 1'b1;
    for (int i = 0; i < 20; i++)
      bus_cycle(16'h1000 + 16'(i), 8'(i), 1'b0, (i < DEPTH), 2'd0, HALF);
    check("ovf_count_full", 64'(fifo_count), 64'd16);
    check("ovf_flag", 64'(ovf), 64'd1);
    check("ovf_cnt4", 64'(ovf_count), 64'd4);
    drain("overflow");
    clr_ovf = 1'b1; @(posedge clk200); #1 clr_ovf = 1'b0;
    check("clr_ovf_flag", 64'(ovf), 64'd0);
    check("clr_ovf_cnt", 64'(ovf_count), 64'd0);

    // Full FIFO with a pop in the push cycle: nothing dropped.
    for (int i = 0; i < DEPTH; i++)
      bus_cycle(16'h2000 + 16'(i), 8'(i), 1'b1, 1'b1, 2'd0, HALF);
    a8_addr = 16'h2100; a8_data = 8'hEE; a8_rw_n = 1'b1;
    tb_ts++;
    q.push_back(mk(tb_ts, 2'd0, 1'b1, 1'b1, 16'h2100, 8'hEE));
    a8_clk = 1'b1;
    repeat (SDLY + 3) @(posedge clk200); #1;
    out_ready = 1'b1;
    @(posedge clk200); #1;
    out_ready = 1'b0;
    check("popfull_count", 64'(fifo_count), 64'd16);
    check("popfull_ovf", 64'(ovf), 64'd0);
    check("popfull_ovf_cnt", 64'(ovf_count), 64'd0);
    repeat (HALF - SDLY - 4) @(posedge clk200);
    #1 a8_clk = 1'b0;
    repeat (HALF) @(posedge clk200); #1;

    // Plain drop, then a drop coinciding with clr_ovf.
    bus_cycle(16'h2200, 8'h00, 1'b1, 1'b0, 2'd0, HALF);
    check("drop1_cnt", 64'(ovf_count), 64'd1);
    a8_addr = 16'h2201; a8_data = 8'h01; a8_rw_n = 1'b1;
    tb_ts++;
    a8_clk = 1'b1;
    repeat (SDLY + 3) @(posedge clk200); #1;
    clr_ovf = 1'b1;
    @(posedge clk200); #1;
    clr_ovf = 1'b0;
    check("clrdrop_ovf", 64'(ovf), 64'd1);
    check("clrdrop_cnt", 64'(ovf_count), 64'd1);
    repeat (HALF - SDLY - 4) @(posedge clk200);
    #1 a8_clk = 1'b0;
    repeat (HALF) @(posedge clk200); #1;
    drain("popfull");

    // Capture disabled for 10 cycles; timestamp keeps advancing.
    enable = 1'b0;
    for (int i = 0; i < 10; i++)
      bus_cycle(16'h3000, 8'(i), 1'b0, 1'b0, 2'd0, HALF);
    check("disabled_empty", 64'(fifo_count), 64'd0);
    enable = 1'b1;
    bus_cycle(16'h3001, 8'h77, 1'b0, 1'b1, 2'd0, HALF);
    drain("enable");

    // Run the timestamp up to its wrap point with capture off.
    enable = 1'b0;
    for (int i = 0; i < 300 && tb_ts != 8'hFD; i++)
      bus_cycle(16'h4000, 8'h00, 1'b1, 1'b0, 2'd0, 30);
    check("wrap_reached", 64'(tb_ts), 64'hFD);
    enable = 1'b1;
    bus_cycle(16'h4001, 8'hF1, 1'b1, 1'b1, 2'd0, HALF);
    bus_cycle(16'h4002, 8'hF2, 1'b1, 1'b1, 2'd0, HALF);
    bus_cycle(16'h4003, 8'hF3, 1'b1, 1'b1, 2'd0, HALF);
    check("wrap_last_ts", 64'(tb_ts), 64'h00);
    drain("wrap");

    // Reset in the middle of the sample delay with entries queued.
    for (int i = 0; i < 3; i++)
      bus_cycle(16'h5000 + 16'(i), 8'(i), 1'b0, 1'b1, 2'd0, HALF);
    check("prereset_count", 64'(fifo_count), 64'd3);
    check("prereset_ovf", 64'(ovf), 64'd1);
    a8_addr = 16'h5100; a8_data = 8'h99; a8_rw_n = 1'b0;
    a8_clk = 1'b1;
    repeat (30) @(posedge clk200); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_data", 64'(out_data), 64'd0);
    check("midrst_count", 64'(fifo_count), 64'd0);
    check("midrst_ovf", 64'(ovf), 64'd0);
    check("midrst_ovf_cnt", 64'(ovf_count), 64'd0);
    q.delete();
    repeat (HALF - 30) @(posedge clk200);
    #1 a8_clk = 1'b0;
    repeat (10) @(posedge clk200);
    #1 rst_n = 1'b1;
    tb_ts = '0;
    repeat (HALF) @(posedge clk200); #1;
    check("postrst_valid", 64'(out_valid), 64'd0);
    check("postrst_count", 64'(fifo_count), 64'd0);
    bus_cycle(16'h5200, 8'h42, 1'b0, 1'b1, 2'd0, HALF);
    check("resume_count", 64'(fifo_count), 64'd1);
    drain("resume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
